a8_bus_capture: RTL
===================

# a8_bus_capture

Downstream consumer of the bus monitor's strobes. It latches the A8 address and R/W on the address strobe and the data byte on the matching write or read strobe. Cycles that hit a configurable address window are packed into 25-bit records and buffered in a FIFO. The FIFO drains to the host-side logic through a valid/ready handshake.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: record slots; power of two, 4..256.
- `WINDOW_BASE`, default 16'hD500: address window match value.
- `WINDOW_MASK`, default 16'hFF00: address bits compared against `WINDOW_BASE`.

Ports:
- `clk`  in  1  100 MHz FPGA clock.
- `a8_rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `a8_addr_strobe`  in  1  one-clk pulse; address/RW valid.
- `a8_write_strobe`  in  1  one-clk pulse; write data valid.
- `a8_read_strobe`  in  1  one-clk pulse; read data valid.
- `a8_clk_falling`  in  1  one-clk pulse; A8 cycle boundary.
- `a8_addr`  in  16  A8 address bus, already synchronised.
- `a8_data`  in  8  A8 data bus, already synchronised.
- `a8_rw_n`  in  1  1 = read, 0 = write.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  25  head record {rw_n, addr[15:0], data[7:0]}.
- `out_ready`  in  1  consumer accepts head this cycle.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied slots.
- `drop_count`  out  8  records lost to a full FIFO; saturates at 255.

## Operation
- FSM states: IDLE, WAIT_DATA, PUSH.
- IDLE → WAIT_DATA on `a8_addr_strobe`, but only if `(a8_addr & WINDOW_MASK) == (WINDOW_BASE & WINDOW_MASK)` and the cycle type is enabled (see Configuration).
  - On that transition, latch `a8_addr` and `a8_rw_n`.
  - A non-matching address or a disabled type leaves the FSM in IDLE.
- WAIT_DATA → PUSH on the strobe that matches the latched R/W:
  - `a8_write_strobe` when rw_n = 0;
  - `a8_read_strobe` when rw_n = 1.
  - On that transition, latch `a8_data`.
  - The non-matching data strobe is ignored.
- WAIT_DATA → IDLE on `a8_clk_falling` before the data strobe. This is an aborted cycle: no record, no drop count.
- PUSH → IDLE unconditionally after one cycle. In that cycle, write the record if space is available; otherwise increment `drop_count`, saturating.
- `a8_addr_strobe` in WAIT_DATA or PUSH is ignored. A new cycle is only accepted from IDLE.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a separate count.
  - Space is available when `fifo_level < FIFO_DEPTH`, or when a pop occurs in the same cycle. A simultaneous push and pop on a full FIFO therefore succeeds and the level stays at `FIFO_DEPTH`.
  - Pop happens when `out_valid & out_ready`. `out_ready` while empty has no effect.
  - `out_data` is the head entry and is held stable while `out_valid & !out_ready`.
- Reset asserted mid-operation immediately clears all state, including FIFO contents.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `fifo_level` = 0, `drop_count` = 0, FSM = IDLE.
- For a data strobe sampled at edge N: FSM is in PUSH after N; record is written at N+1; `out_valid` and `out_data` reflect it after N+1.
- Pop at edge M: `fifo_level` decrements after M; the next head is presented after M.
- Strobe spacing is 24 clk (address→write) or 31 clk (address→read). The one-cycle PUSH always completes well before the next `a8_addr_strobe`.
- Throughput is at most one record per A8 cycle (~558 ns), so a consumer draining one record per clk never overflows.

## Configuration
- `A8_CAPTURE_READS_EN` defined: both read and write cycles are captured.
- Undefined: the IDLE → WAIT_DATA transition requires rw_n = 0. Read cycles are never recorded, and `a8_read_strobe` is unused.

## Test plan
- Write cycle: addr 16'hD501, rw_n = 0, data 8'h5A, write strobe 24 clk after the address strobe → `out_valid` rises 2 clk after the write strobe with `out_data` = {1'b0, 16'hD501, 8'h5A}; `fifo_level` = 1.
- Address 16'hD401 outside the window → no record; `fifo_level` stays 0.
- Read cycle: addr 16'hD5FF, data 8'hC3 → record {1'b1, 16'hD5FF, 8'hC3} when `A8_CAPTURE_READS_EN` is defined; no record when it is undefined.
- `a8_clk_falling` between the address strobe and the data strobe → no record, `drop_count` = 0, next cycle captured normally.
- `out_ready` = 0 for 18 in-window writes with depth 16 → `fifo_level` = 16, `drop_count` = 2, the 16 oldest records preserved in order. Then drain with `out_ready` = 1 → 16 pops, `out_valid` falls.
- Full FIFO with `out_ready` = 1 during the PUSH cycle → record accepted, `fifo_level` stays 16, `drop_count` unchanged. Reset asserted mid-WAIT_DATA → all outputs return to reset values immediately.

Source files
------------

// File: rtl/a8_bus_capture.sv
// ---------------------------------------------------------------------------
// a8_bus_capture
//
// Consumes the A8 bus monitor's strobes and records bus cycles that fall in
// an address window. The address and R/W are latched on the address strobe,
// the data byte on the write or read strobe that matches the latched R/W.
// Each captured cycle becomes a 25-bit record {rw_n, addr[15:0], data[7:0]}
// that is buffered in a circular FIFO and drained through valid/ready.
//
// Optional feature (compile-time macro A8_CAPTURE_READS_EN):
//   defined   - read and write cycles are both captured
//   undefined - only write cycles (rw_n = 0) are captured
//
// Parameters:
//   FIFO_DEPTH   record slots, power of two, 4..256
//   WINDOW_BASE  address window match value
//   WINDOW_MASK  address bits compared against WINDOW_BASE
//
// Ports:
//   clk              in   system clock
//   a8_rst_n         in   asynchronous active-low reset
//   a8_addr_strobe   in   one-clk pulse, a8_addr / a8_rw_n valid
//   a8_write_strobe  in   one-clk pulse, write data valid
//   a8_read_strobe   in   one-clk pulse, read data valid
//   a8_clk_falling   in   one-clk pulse, A8 cycle boundary
//   a8_addr          in   A8 address bus (synchronised)
//   a8_data          in   A8 data bus (synchronised)
//   a8_rw_n          in   1 = read, 0 = write
//   out_valid        out  FIFO non-empty
//   out_data         out  head record, zero while empty
//   out_ready        in   consumer takes the head this cycle
//   fifo_level       out  occupied slots
//   drop_count       out  records lost to a full FIFO, saturates at 255
// ---------------------------------------------------------------------------
module a8_bus_capture #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] WINDOW_BASE = 16'hD500,
    parameter logic [15:0] WINDOW_MASK = 16'hFF00,
    localparam int         PTR_W       = $clog2(FIFO_DEPTH),
    localparam int         LVL_W       = PTR_W + 1
) (
    input  logic             clk,
    input  logic             a8_rst_n,
    input  logic             a8_addr_strobe,
    input  logic             a8_write_strobe,
    input  logic             a8_read_strobe,
    input  logic             a8_clk_falling,
    input  logic [15:0]      a8_addr,
    input  logic [7:0]       a8_data,
    input  logic             a8_rw_n,
    output logic             out_valid,
    output logic [24:0]      out_data,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [7:0]       drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        PUSH
    } state_t;

    state_t state, state_next;

    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  data_q;

    logic addr_load;
    logic data_load;
    logic push_req;

    logic addr_hit;
    logic type_ok;
    logic data_strobe;

    assign addr_hit = (a8_addr & WINDOW_MASK) == (WINDOW_BASE & WINDOW_MASK);

`ifdef A8_CAPTURE_READS_EN
    assign type_ok = 1'b1;
`else
    assign type_ok = ~a8_rw_n;
`endif

    // Only the strobe matching the latched direction completes the cycle;
    // the other one is ignored.
    assign data_strobe = rw_q ? a8_read_strobe : a8_write_strobe;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        addr_load  = 1'b0;
        data_load  = 1'b0;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (a8_addr_strobe && addr_hit && type_ok) begin
                    state_next = WAIT_DATA;
                    addr_load  = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (data_strobe) begin
                    state_next = PUSH;
                    data_load  = 1'b1;
                end else if (a8_clk_falling) begin
                    // Cycle ended without its data phase: discard silently.
                    state_next = IDLE;
                end
            end
            PUSH: begin
                push_req   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            rw_q   <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_next;
            if (addr_load) begin
                addr_q <= a8_addr;
                rw_q   <= a8_rw_n;
            end
            if (data_load) begin
                data_q <= a8_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    logic [24:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    logic pop;
    logic space;
    logic push;
    logic drop;

    assign pop   = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign space = (count != LVL_W'(FIFO_DEPTH)) | pop;
    assign push  = push_req & space;
    assign drop  = push_req & ~space;

    // NOTE: the storage array has no reset; the count and pointers define
    // which entries are live, and out_data is gated while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {rw_q, addr_q, data_q};
        end
    end

    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = count;

endmodule
